// File: rtl/sniffer_pkg.sv
// Shared constants and state encoding for the sample buffer controller.
package sniffer_pkg;

  localparam int unsigned DEPTH = 3584;
  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_POST    = 3'd2,
    ST_DONE    = 3'd3,
    ST_RD_ADDR = 3'd4,
    ST_RD_WAIT = 3'd5,
    ST_RD_OUT  = 3'd6
  } state_e;

endpackage

// File: rtl/BRAM4k8bit.sv
// 4k x 8 single-port block RAM: synchronous write, one-cycle registered read.
module BRAM4k8bit #(
  parameter int unsigned AW = sniffer_pkg::AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  output logic [7:0]    dout
);

  logic [7:0] mem [2**AW];

  // Write when enabled with WE, otherwise read into the output register.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/sample_buffer_ctrl.sv
// Circular pre/post-trigger capture buffer with a ready/valid readout port.
module sample_buffer_ctrl #(
  parameter int unsigned DEPTH = sniffer_pkg::DEPTH,
  parameter int unsigned AW    = sniffer_pkg::AW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ARM,
  input  logic [AW-1:0] POST_COUNT,
  input  logic          SAMPLE_VALID,
  input  logic [7:0]    SAMPLE,
  input  logic          TRIG,
  input  logic          READ_REQ,
  input  logic          RD_READY,
  output logic          RD_VALID,
  output logic [7:0]    RD_DATA,
  output logic          RD_LAST,
  output logic [2:0]    STATE,
  output logic          WRAPPED
);

  import sniffer_pkg::state_e;
  import sniffer_pkg::ST_IDLE;
  import sniffer_pkg::ST_ARMED;
  import sniffer_pkg::ST_POST;
  import sniffer_pkg::ST_DONE;
  import sniffer_pkg::ST_RD_ADDR;
  import sniffer_pkg::ST_RD_WAIT;
  import sniffer_pkg::ST_RD_OUT;

  // Read count needs one extra bit so a full buffer (DEPTH) is representable.
  localparam int unsigned    CW        = AW + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] rc_q, rc_d;
  logic          wrapped_q, wrapped_d;
  logic          rd_valid_q, rd_valid_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_last_q, rd_last_d;

  logic          bram_we;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic [7:0]    bram_dout;
  logic          capturing;
  logic [CW-1:0] req_cnt;

  assign capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
  assign req_cnt   = wrapped_q ? FULL_CNT : {1'b0, wp_q};

  BRAM4k8bit #(.AW(AW)) u_bram (
    .clk  (CLK),
    .we   (bram_we),
    .en   (bram_en),
    .addr (bram_addr),
    .din  (SAMPLE),
    .dout (bram_dout)
  );

  // Next-state, pointer/counter updates and BRAM control.
  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    pc_d       = pc_q;
    rp_d       = rp_q;
    rc_d       = rc_q;
    wrapped_d  = wrapped_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_last_d  = rd_last_q;
    bram_we    = 1'b0;
    bram_en    = 1'b0;
    bram_addr  = capturing ? wp_q : rp_q;

    // Every valid sample during capture lands at WP, which wraps at DEPTH-1.
    if (capturing && SAMPLE_VALID) begin
      bram_we = 1'b1;
      bram_en = 1'b1;
      if (wp_q == LAST_ADDR) begin
        wp_d      = '0;
        wrapped_d = 1'b1;
      end else begin
        wp_d = wp_q + AW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (ARM) begin
          wp_d      = '0;
          wrapped_d = 1'b0;
          pc_d      = (POST_COUNT > LAST_ADDR) ? LAST_ADDR : POST_COUNT;
          state_d   = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (SAMPLE_VALID && TRIG) state_d = (pc_q == '0) ? ST_DONE : ST_POST;
      end
      ST_POST: begin
        // PC counts the post-trigger samples still to be taken.
        if (SAMPLE_VALID) begin
          pc_d = pc_q - AW'(1);
          if (pc_q <= AW'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ARM) begin
          wp_d      = '0;
          wrapped_d = 1'b0;
          pc_d      = (POST_COUNT > LAST_ADDR) ? LAST_ADDR : POST_COUNT;
          state_d   = ST_ARMED;
        end else if (READ_REQ) begin
          // Oldest sample sits at WP once the buffer has wrapped.
          rp_d    = wrapped_q ? wp_q : '0;
          rc_d    = req_cnt;
          state_d = (req_cnt == '0) ? ST_IDLE : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        bram_en = 1'b1;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        rd_data_d  = bram_dout;
        rd_valid_d = 1'b1;
        rd_last_d  = (rc_q == CW'(1));
        state_d    = ST_RD_OUT;
      end
      ST_RD_OUT: begin
        if (RD_READY) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          rp_d       = (rp_q == LAST_ADDR) ? '0 : rp_q + AW'(1);
          rc_d       = rc_q - CW'(1);
          state_d    = (rc_q == CW'(1)) ? ST_IDLE : ST_RD_ADDR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any capture or readout.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      wp_q       <= '0;
      pc_q       <= '0;
      rp_q       <= '0;
      rc_q       <= '0;
      wrapped_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      pc_q       <= pc_d;
      rp_q       <= rp_d;
      rc_q       <= rc_d;
      wrapped_q  <= wrapped_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
    end
  end

  assign RD_VALID = rd_valid_q;
  assign RD_DATA  = rd_data_q;
  assign RD_LAST  = rd_last_q;
  assign STATE    = state_q;
  assign WRAPPED  = wrapped_q;

endmodule

// File: tb/tb_sample_buffer_ctrl.sv
// Bench for sample_buffer_ctrl: directed scenarios with randomized data,
// gaps and back-pressure, checked against a queue-based capture model.
module tb_sample_buffer_ctrl;

  localparam int unsigned DEPTH   = 3584;
  localparam int unsigned AW      = 12;
  localparam int          DEPTH_I = 3584;

  logic          CLK = 1'b0;
  logic          RST;
  logic          ARM;
  logic [AW-1:0] POST_COUNT;
  logic          SAMPLE_VALID;
  logic [7:0]    SAMPLE;
  logic          TRIG;
  logic          READ_REQ;
  logic          RD_READY;
  logic          RD_VALID;
  logic [7:0]    RD_DATA;
  logic          RD_LAST;
  logic [2:0]    STATE;
  logic          WRAPPED;

  int total = 0;
  int bad   = 0;

  logic [7:0] gen_q[$];
  logic [7:0] exp_q[$];
  bit         exp_wrapped;

  sample_buffer_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .ARM          (ARM),
    .POST_COUNT   (POST_COUNT),
    .SAMPLE_VALID (SAMPLE_VALID),
    .SAMPLE       (SAMPLE),
    .TRIG         (TRIG),
    .READ_REQ     (READ_REQ),
    .RD_READY     (RD_READY),
    .RD_VALID     (RD_VALID),
    .RD_DATA      (RD_DATA),
    .RD_LAST      (RD_LAST),
    .STATE        (STATE),
    .WRAPPED      (WRAPPED)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a capture; the model keeps every valid sample up to trigger + post count.
  task automatic capture(input int pc, input int trig_idx, input int nsamp,
                         input bit gaps, input bit rnd_data, input logic [7:0] base);
    int pc_eff;
    int idx;
    int guard;
    int start;
    logic [7:0] d;
    pc_eff = (pc > DEPTH_I - 1) ? DEPTH_I - 1 : pc;
    gen_q.delete();
    @(negedge CLK);
    ARM = 1'b1;
    POST_COUNT = AW'(pc);
    @(negedge CLK);
    ARM = 1'b0;
    POST_COUNT = AW'($urandom);
    idx = 0;
    guard = 0;
    while (idx < nsamp && guard < 4 * nsamp + 100) begin
      guard++;
      if (gaps && $urandom_range(2) == 0) begin
        SAMPLE_VALID = 1'b0;
        SAMPLE = 8'($urandom);
        TRIG = 1'($urandom);
      end else begin
        d = rnd_data ? 8'($urandom) : 8'(int'(base) + idx);
        SAMPLE_VALID = 1'b1;
        SAMPLE = d;
        TRIG = (idx == trig_idx) || (idx > trig_idx && 1'($urandom));
        if (idx <= trig_idx + pc_eff) gen_q.push_back(d);
        idx++;
      end
      @(negedge CLK);
    end
    SAMPLE_VALID = 1'b0;
    TRIG = 1'b0;
    check("cap_done_state", STATE, 3);
    exp_wrapped = (gen_q.size() >= DEPTH_I);
    check("cap_wrapped", WRAPPED, exp_wrapped);
    exp_q.delete();
    start = (gen_q.size() > DEPTH_I) ? gen_q.size() - DEPTH_I : 0;
    for (int i = start; i < gen_q.size(); i++) exp_q.push_back(gen_q[i]);
  endtask

  // Read the buffer back. mode 0: always ready, 1: random ready, 2: ready held low 5 cycles per sample.
  task automatic readout(input int mode);
    int k;
    int cyc;
    int hold_cnt;
    int last_acc;
    int n;
    bit held;
    bit rdy;
    logic [7:0] prev;
    n = exp_q.size();
    @(negedge CLK);
    READ_REQ = 1'b1;
    @(negedge CLK);
    READ_REQ = 1'b0;
    k = 0;
    cyc = 0;
    hold_cnt = 0;
    last_acc = -3;
    held = 1'b0;
    prev = '0;
    while (k < n && cyc < 12 * n + 50) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom);
        default: rdy = (hold_cnt >= 5);
      endcase
      RD_READY = rdy;
      if (held) begin
        check("hold_valid", RD_VALID, 1);
        check("hold_data", RD_DATA, prev);
      end
      held = 1'b0;
      if (RD_VALID === 1'b1) begin
        check("rd_last", RD_LAST, (k == n - 1));
        if (rdy) begin
          check("rd_data", RD_DATA, exp_q[k]);
          check("rd_rate", ((cyc - last_acc) >= 3), 1);
          last_acc = cyc;
          k++;
          hold_cnt = 0;
        end else begin
          held = 1'b1;
          prev = RD_DATA;
          hold_cnt++;
        end
      end else begin
        check("rd_last_idle", RD_LAST, 0);
      end
      cyc++;
      @(negedge CLK);
    end
    RD_READY = 1'b0;
    check("rd_count", k, n);
    check("rd_end_state", STATE, 0);
    check("rd_end_valid", RD_VALID, 0);
  endtask

  initial begin
    int pc;
    int tr;
    int ns;
    bit seen;

    RST = 1'b1;
    ARM = 1'b0;
    POST_COUNT = '0;
    SAMPLE_VALID = 1'b0;
    SAMPLE = '0;
    TRIG = 1'b0;
    READ_REQ = 1'b0;
    RD_READY = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_state", STATE, 0);
    check("rst_valid", RD_VALID, 0);
    check("rst_last", RD_LAST, 0);
    check("rst_data", RD_DATA, 0);
    check("rst_wrapped", WRAPPED, 0);
    RST = 1'b0;

    // READ_REQ outside DONE is ignored.
    @(negedge CLK);
    READ_REQ = 1'b1;
    @(negedge CLK);
    READ_REQ = 1'b0;
    check("idle_readreq_ignored", STATE, 0);

    // Basic capture: 0x00..0x09, trigger on 0x05, four post samples.
    capture(4, 5, 10, 1'b0, 1'b0, 8'h00);
    readout(0);

    // Zero post count, trigger on the first sample.
    capture(0, 0, 1, 1'b0, 1'b0, 8'hA5);
    readout(1);

    // Back-pressure: ready held low five cycles per sample.
    capture(6, 20, 40, 1'b1, 1'b1, 8'h00);
    readout(2);

    // Randomized short captures with gaps and random ready.
    for (int r = 0; r < 3; r++) begin
      pc = $urandom_range(40);
      tr = $urandom_range(60);
      ns = tr + pc + 1 + $urandom_range(5);
      capture(pc, tr, ns, 1'b1, 1'b1, 8'h00);
      readout(1);
    end

    // ARM beats READ_REQ in DONE.
    capture(1, 2, 5, 1'b0, 1'b1, 8'h00);
    @(negedge CLK);
    ARM = 1'b1;
    READ_REQ = 1'b1;
    POST_COUNT = AW'(3);
    @(negedge CLK);
    ARM = 1'b0;
    READ_REQ = 1'b0;
    check("arm_prio_state", STATE, 1);
    seen = 1'b0;
    repeat (6) begin
      if (RD_VALID !== 1'b0) seen = 1'b1;
      @(negedge CLK);
    end
    check("arm_prio_no_read", seen, 0);
    check("arm_prio_still_armed", STATE, 1);
    capture(3, 4, 12, 1'b1, 1'b1, 8'h00);
    readout(0);

    // Reset pulse in the middle of POST.
    @(negedge CLK);
    ARM = 1'b1;
    POST_COUNT = AW'(50);
    @(negedge CLK);
    ARM = 1'b0;
    for (int i = 0; i < 8; i++) begin
      SAMPLE_VALID = 1'b1;
      SAMPLE = 8'(i);
      TRIG = (i == 3);
      @(negedge CLK);
    end
    SAMPLE_VALID = 1'b0;
    TRIG = 1'b0;
    check("mid_post_state", STATE, 2);
    #2 RST = 1'b1;
    #1;
    check("mid_post_rst_state", STATE, 0);
    check("mid_post_rst_valid", RD_VALID, 0);
    check("mid_post_rst_wrapped", WRAPPED, 0);
    @(negedge CLK);
    RST = 1'b0;
    capture(4, 5, 10, 1'b0, 1'b0, 8'h00);
    readout(0);

    // Long capture that wraps, extra samples after DONE are dropped.
    capture(2, 3990, 4000, 1'b0, 1'b0, 8'h00);
    readout(0);

    // POST_COUNT beyond DEPTH-1 is clamped.
    capture(4095, 10, 3600, 1'b0, 1'b1, 8'h00);
    readout(1);

    // Reset during readout drops the pending sample.
    capture(2, 3, 8, 1'b0, 1'b1, 8'h00);
    @(negedge CLK);
    READ_REQ = 1'b1;
    @(negedge CLK);
    READ_REQ = 1'b0;
    repeat (3) @(negedge CLK);
    check("mid_read_valid", RD_VALID, 1);
    #2 RST = 1'b1;
    #1;
    check("mid_read_rst_valid", RD_VALID, 0);
    check("mid_read_rst_state", STATE, 0);
    check("mid_read_rst_data", RD_DATA, 0);
    @(negedge CLK);
    RST = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
